// File: rtl/lkahead_destport_decoder.sv
// Look-ahead destination-port decoder: turns the {x,y,a,b} field of a head flit into a one-hot switch request.
// Optional LKAHEAD_ADAPT_RESELECT_EN: re-evaluates the adaptive x/y choice every cycle until the grant.
module lkahead_destport_decoder #(
    parameter int P  = 5,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flit_in_wr,
    input  logic          hdr_flg_in,
    input  logic          tail_flg_in,
    input  logic [P-2:0]  lkdestport_encoded,
    input  logic [CW-1:0] credit_x,
    input  logic [CW-1:0] credit_y,
    input  logic          port_grant,
    output logic [P-1:0]  dest_port,
    output logic          dest_port_valid,
    output logic          busy,
    output logic          hdr_err
);

    // state | meaning
    // IDLE  | no packet in flight
    // REQ   | head captured, request pending
    // HOLD  | granted, waiting for the tail
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    localparam logic [P-1:0] LOCAL = P'(1);
    localparam logic [P-1:0] EAST  = P'(2);
    localparam logic [P-1:0] NORTH = P'(4);
    localparam logic [P-1:0] WEST  = P'(8);
    localparam logic [P-1:0] SOUTH = P'(16);

    state_t       state, state_next;
    logic [P-2:0] cap;
    logic         sel_y;
    logic         tail_seen;
    logic         capture;
    logic         tail_now;
    logic         y_better;

    function automatic logic [P-1:0] decode(input logic [P-2:0] f, input logic sy);
        logic [P-1:0] xp;
        logic [P-1:0] yp;
        logic [P-1:0] r;
        xp = f[P-2] ? EAST : WEST;
        yp = f[P-3] ? NORTH : SOUTH;
        case (f[1:0])
            2'b00:   r = LOCAL;
            2'b10:   r = xp;
            2'b01:   r = yp;
            default: r = sy ? yp : xp;
        endcase
        return r;
    endfunction

    assign capture  = (state == IDLE) && flit_in_wr && hdr_flg_in;
    // A head flit outside IDLE is discarded entirely, including any tail marker it carries.
    assign tail_now = flit_in_wr && tail_flg_in && !hdr_flg_in;
    assign y_better = credit_y > credit_x;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (port_grant) begin
                    state_next = (tail_seen || tail_now) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (tail_now) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dest_port_valid = (state == REQ);
        busy            = (state != IDLE);
        dest_port       = (state == IDLE) ? '0 : decode(cap, sel_y);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap       <= '0;
            sel_y     <= 1'b0;
            tail_seen <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            if (capture) begin
                cap   <= lkdestport_encoded;
                sel_y <= y_better;
            end
`ifdef LKAHEAD_ADAPT_RESELECT_EN
            else if (state == REQ && !port_grant && cap[1:0] == 2'b11) begin
                sel_y <= y_better;
            end
`endif

            if (state != IDLE && state_next == IDLE) begin
                tail_seen <= 1'b0;
            end else if (capture) begin
                tail_seen <= tail_flg_in;
            end else if (state == REQ && tail_now) begin
                tail_seen <= 1'b1;
            end

            if (state != IDLE && flit_in_wr && hdr_flg_in) begin
                hdr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lkahead_destport_decoder.sv
// Directed bench for lkahead_destport_decoder; follows the same LKAHEAD_ADAPT_RESELECT_EN define as the design.
module tb_lkahead_destport_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flit_in_wr = 1'b0;
    logic       hdr_flg_in = 1'b0;
    logic       tail_flg_in = 1'b0;
    logic [3:0] lkdestport_encoded = '0;
    logic [3:0] credit_x = '0;
    logic [3:0] credit_y = '0;
    logic       port_grant = 1'b0;
    logic [4:0] dest_port;
    logic       dest_port_valid;
    logic       busy;
    logic       hdr_err;

    int n_checks = 0;
    int n_fail   = 0;

    lkahead_destport_decoder #(.P(5), .CW(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .flit_in_wr         (flit_in_wr),
        .hdr_flg_in         (hdr_flg_in),
        .tail_flg_in        (tail_flg_in),
        .lkdestport_encoded (lkdestport_encoded),
        .credit_x           (credit_x),
        .credit_y           (credit_y),
        .port_grant         (port_grant),
        .dest_port          (dest_port),
        .dest_port_valid    (dest_port_valid),
        .busy               (busy),
        .hdr_err            (hdr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic hdr, input logic tl, input logic [3:0] enc,
                         input logic [3:0] cx, input logic [3:0] cy, input logic gnt);
        flit_in_wr         = wr;
        hdr_flg_in         = hdr;
        tail_flg_in        = tl;
        lkdestport_encoded = enc;
        credit_x           = cx;
        credit_y           = cy;
        port_grant         = gnt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-flit packet: head+tail, one valid cycle, grant, back to IDLE.
    task automatic single(input string tag, input logic [3:0] enc, input logic [3:0] cx,
                          input logic [3:0] cy, input logic [4:0] exp);
        drive(1, 1, 1, enc, cx, cy, 0);
        tick();
        chk({tag, "_dest"}, 32'(dest_port), 32'(exp));
        chk({tag, "_valid"}, 32'(dest_port_valid), 32'd1);
        drive(0, 0, 0, 4'h0, 0, 0, 1);
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        drive(0, 0, 0, 4'h0, 0, 0, 0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_dest", 32'(dest_port), 32'd0);
        chk("rst_valid", 32'(dest_port_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(hdr_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Head 1010 (x=1, ab=10 -> east), two valid cycles, tail three flits after the head
        drive(1, 1, 0, 4'b1010, 0, 0, 0);
        tick();
        chk("t1_valid1", 32'(dest_port_valid), 32'd1);
        chk("t1_dest", 32'(dest_port), 32'h02);
        drive(1, 0, 0, 4'h0, 0, 0, 0);
        tick();
        chk("t1_valid2", 32'(dest_port_valid), 32'd1);
        drive(1, 0, 0, 4'h0, 0, 0, 1);
        tick();
        chk("t1_valid_drop", 32'(dest_port_valid), 32'd0);
        chk("t1_hold_dest", 32'(dest_port), 32'h02);
        chk("t1_hold_busy", 32'(busy), 32'd1);
        drive(1, 0, 1, 4'h0, 0, 0, 0);
        tick();
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_dest_clr", 32'(dest_port), 32'd0);
        drive(0, 0, 0, 4'h0, 0, 0, 0);

        // Head+tail, grant held from the capture cycle (ignored in IDLE); {x,y,a,b}=0001 -> south
        drive(1, 1, 1, 4'b0001, 0, 0, 1);
        tick();
        chk("t2_dest", 32'(dest_port), 32'h10);
        chk("t2_valid", 32'(dest_port_valid), 32'd1);
        drive(0, 0, 0, 4'h0, 0, 0, 1);
        tick();
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_valid_off", 32'(dest_port_valid), 32'd0);
        drive(0, 0, 0, 4'h0, 0, 0, 0);

        single("adapt_y", 4'b0111, 4'd3, 4'd5, 5'b00100);
        single("adapt_tie", 4'b0111, 4'd5, 4'd5, 5'b01000);
        single("adapt_x", 4'b1011, 4'd9, 4'd2, 5'b00010);
        single("local", 4'b0100, 4'd0, 4'd0, 5'b00001);
        single("north", 4'b1101, 4'd0, 4'd0, 5'b00100);
        single("west", 4'b0110, 4'd0, 4'd0, 5'b01000);

        // Non-head flits in IDLE do nothing
        drive(1, 0, 1, 4'b1010, 0, 0, 1);
        tick();
        chk("nonhead_busy", 32'(busy), 32'd0);
        chk("nonhead_err", 32'(hdr_err), 32'd0);
        drive(0, 0, 0, 4'h0, 0, 0, 0);

        // Second head during HOLD
        drive(1, 1, 0, 4'b1010, 0, 0, 0);
        tick();
        drive(0, 0, 0, 4'h0, 0, 0, 1);
        tick();
        chk("t4_hold", 32'(dest_port_valid), 32'd0);
        drive(1, 1, 0, 4'b0000, 0, 0, 0);
        tick();
        chk("t4_err", 32'(hdr_err), 32'd1);
        chk("t4_dest", 32'(dest_port), 32'h02);
        chk("t4_busy", 32'(busy), 32'd1);
        drive(1, 0, 1, 4'h0, 0, 0, 0);
        tick();
        chk("t4_exit", 32'(busy), 32'd0);
        chk("t4_err_sticky", 32'(hdr_err), 32'd1);
        drive(0, 0, 0, 4'h0, 0, 0, 0);

        // Asynchronous reset in REQ, then a local head
        drive(1, 1, 0, 4'b1010, 0, 0, 0);
        tick();
        chk("t5_req", 32'(dest_port_valid), 32'd1);
        drive(0, 0, 0, 4'h0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_dest", 32'(dest_port), 32'd0);
        chk("t5_async_valid", 32'(dest_port_valid), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_err", 32'(hdr_err), 32'd0);
        #1 reset = 1'b1;
        drive(1, 1, 0, 4'b0000, 0, 0, 0);
        tick();
        chk("t5_local", 32'(dest_port), 32'h01);
        chk("t5_local_valid", 32'(dest_port_valid), 32'd1);
        drive(0, 0, 0, 4'h0, 0, 0, 1);
        tick();
        drive(1, 0, 1, 4'h0, 0, 0, 0);
        tick();
        chk("t5_done", 32'(busy), 32'd0);
        drive(0, 0, 0, 4'h0, 0, 0, 0);

        // Credits flip while waiting for grant on {x,y,a,b}=1111
        drive(1, 1, 0, 4'b1111, 4'd5, 4'd2, 0);
        tick();
        chk("t6_first", 32'(dest_port), 32'h02);
        drive(0, 0, 0, 4'h0, 4'd2, 4'd5, 0);
        tick();
`ifdef LKAHEAD_ADAPT_RESELECT_EN
        chk("t6_moved", 32'(dest_port), 32'h04);
`else
        chk("t6_fixed", 32'(dest_port), 32'h02);
`endif
        chk("t6_valid", 32'(dest_port_valid), 32'd1);
        drive(0, 0, 0, 4'h0, 4'd5, 4'd2, 1);
        tick();
`ifdef LKAHEAD_ADAPT_RESELECT_EN
        chk("t6_frozen", 32'(dest_port), 32'h04);
`else
        chk("t6_frozen", 32'(dest_port), 32'h02);
`endif
        drive(1, 0, 1, 4'h0, 0, 0, 0);
        tick();
        chk("t6_done", 32'(busy), 32'd0);
        drive(0, 0, 0, 4'h0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
